lfsr_reconfig_gen: RTL

- Parametrised, runtime-reconfigurable LFSR; next generation of the team's configurable-tap LFSR.
- Adds:
  - Fibonacci/Galois mode select
  - seed/tap load over a valid/ready config port
  - valid/ready output stream
  - all-zero lock-up detection with automatic recovery
  - sequence-wrap detection with a measured-period output
- Feeds BIST pattern generation and scrambler blocks.

---
 rtl/lfsr_pkg.sv | 16 +
 rtl/lfsr_next_state.sv | 29 ++
 rtl/lfsr_reconfig_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the reconfigurable LFSR generator.
//   lfsr_state_e : control FSM states (idle / run / one-cycle lock-up recovery)
//   MODE_FIB     : Fibonacci (external XOR) feedback
//   MODE_GAL     : Galois (internal XOR) feedback
package lfsr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StRecover
  } lfsr_state_e;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational one-step LFSR update.
//   state : current register value
//   taps  : tap mask
//   mode  : MODE_FIB or MODE_GAL
//   next  : register value after one step
module lfsr_next_state
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] state,
  input  logic [WIDTH-1:0] taps,
  input  logic             mode,
  output logic [WIDTH-1:0] next
);

  logic fb;

  always_comb begin
    fb = ^(state & taps);
    if (mode == MODE_GAL) begin
      // Shift toward the LSB; the bit shifted out folds back in through the taps.
      next = (state >> 1) ^ (state[0] ? taps : '0);
    end else begin
      next = {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_reconfig_gen.sv
// Runtime-reconfigurable LFSR pattern source with valid/ready config and output ports.
//   clk, reset            : clock, asynchronous active-low reset
//   enable                : run request; low holds state
//   cfg_valid/cfg_ready   : config handshake carrying cfg_mode, cfg_taps, cfg_seed
//   out_valid/out_ready   : output stream handshake; lfsr_out is the current state
//   wrap                  : one-cycle pulse when the state returns to the seed
//   period                : steps in the last completed cycle (0 = not measured)
//   lockup                : sticky, set after recovering from an all-zero state
//   cfg_err               : one-cycle pulse when a zero tap mask or seed was replaced
module lfsr_reconfig_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] DEFAULT_TAPS = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_mode,
  input  logic [WIDTH-1:0] cfg_taps,
  input  logic [WIDTH-1:0] cfg_seed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             lockup,
  output logic             cfg_err
);

  lfsr_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] step_cnt_q, step_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;
  logic             cfg_err_q, cfg_err_d;

  logic [WIDTH-1:0] lfsr_next;
  logic             cfg_accept;
  logic             advance;
  logic             taps_zero;
  logic             seed_zero;

  lfsr_next_state #(
    .WIDTH(WIDTH)
  ) u_next_state (
    .state(state_q),
    .taps (taps_q),
    .mode (mode_q),
    .next (lfsr_next)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle: begin
        if (enable) fsm_d = StRun;
      end
      StRun: begin
        // A same-cycle config reloads a non-zero seed, so it cancels recovery.
        if (!cfg_accept && (state_q == '0)) begin
          fsm_d = StRecover;
        end else if (!enable) begin
          fsm_d = StIdle;
        end
      end
      StRecover: begin
        fsm_d = enable ? StRun : StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  // FSM outputs; out_valid never looks at out_ready.
  always_comb begin
    cfg_ready = (fsm_q != StRecover);
    out_valid = (fsm_q == StRun) && enable;
  end

  assign cfg_accept = cfg_valid && cfg_ready;
  assign advance    = out_valid && out_ready;
  assign taps_zero  = (cfg_taps == '0);
  assign seed_zero  = (cfg_seed == '0);

  // Datapath next-state: config beats recovery beats an output step.
  always_comb begin
    state_d    = state_q;
    taps_d     = taps_q;
    seed_d     = seed_q;
    mode_d     = mode_q;
    step_cnt_d = step_cnt_q;
    period_d   = period_q;
    lockup_d   = lockup_q;
    wrap_d     = 1'b0;
    cfg_err_d  = 1'b0;
    if (cfg_accept) begin
      mode_d     = cfg_mode;
      taps_d     = taps_zero ? DEFAULT_TAPS : cfg_taps;
      seed_d     = seed_zero ? DEFAULT_SEED : cfg_seed;
      state_d    = seed_d;
      step_cnt_d = '0;
      period_d   = '0;
      lockup_d   = 1'b0;
      cfg_err_d  = taps_zero || seed_zero;
    end else if (fsm_q == StRecover) begin
      state_d    = seed_q;
      step_cnt_d = '0;
      lockup_d   = 1'b1;
    end else if (advance) begin
      state_d = lfsr_next;
      if (lfsr_next == seed_q) begin
        wrap_d     = 1'b1;
        period_d   = step_cnt_q + WIDTH'(1);
        step_cnt_d = '0;
      end else begin
        step_cnt_d = step_cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= DEFAULT_SEED;
      taps_q     <= DEFAULT_TAPS;
      seed_q     <= DEFAULT_SEED;
      mode_q     <= MODE_FIB;
      step_cnt_q <= '0;
      period_q   <= '0;
      lockup_q   <= 1'b0;
      wrap_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      taps_q     <= taps_d;
      seed_q     <= seed_d;
      mode_q     <= mode_d;
      step_cnt_q <= step_cnt_d;
      period_q   <= period_d;
      lockup_q   <= lockup_d;
      wrap_q     <= wrap_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign lfsr_out = state_q;
  assign wrap     = wrap_q;
  assign period   = period_q;
  assign lockup   = lockup_q;
  assign cfg_err  = cfg_err_q;

endmodule
